fm_op_sequencer: RTL

- Time-multiplexes the shared FM operator datapath (phase accumulator, envelope, output stages) across all operators.
- On each sample tick, sweeps op_sel through operators 0..NUM_OPS-1.
- Gives each operator a fixed slot of SLOT_CYCLES clocks and issues one `next` write strobe per slot.
- Converts per-operator key-on levels into single-slot `restart` requests, so an operator's phase clears exactly once per key-on edge.

---
 rtl/fm_op_sequencer_if.sv | 25 ++
 rtl/fm_op_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fm_op_sequencer_if.sv
// Handshake bundle between the FM operator sequencer and the shared operator datapath.
interface fm_op_sequencer_if #(
    parameter int unsigned NUM_OPS = 36,
    parameter int unsigned OP_W    = 6
);
    logic               sample_tick;
    logic [NUM_OPS-1:0] key_on;
    logic [OP_W-1:0]    op_sel;
    logic [3:0]         stage;
    logic               next;
    logic               restart;
    logic               busy;
    logic               sample_done;
    logic               overrun;

    modport master (
        input  sample_tick, key_on,
        output op_sel, stage, next, restart, busy, sample_done, overrun
    );

    modport slave (
        output sample_tick, key_on,
        input  op_sel, stage, next, restart, busy, sample_done, overrun
    );
endinterface

// File: rtl/fm_op_sequencer.sv
// Sweeps the shared FM operator datapath across all operators once per sample tick,
// one fixed-length slot per operator, turning key-on levels into one-slot restart requests.
module fm_op_sequencer #(
    parameter int unsigned NUM_OPS     = 36,
    parameter int unsigned SLOT_CYCLES = 4,
    parameter int unsigned OP_W        = 6
) (
    input  logic                clk,
    input  logic                reset,
    fm_op_sequencer_if.master   bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [OP_W-1:0] LastOp    = OP_W'(NUM_OPS - 1);
    localparam logic [3:0]      LastStage = 4'(SLOT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    op_sel_q, op_sel_d;
    logic [3:0]         stage_q, stage_d;
    logic               next_q, next_d;
    logic               restart_q, restart_d;
    logic               busy_q, busy_d;
    logic               sample_done_q, sample_done_d;
    logic               overrun_q, overrun_d;
    logic               pending_q, pending_d;
    logic               key_snap_q, key_snap_d;
    logic [NUM_OPS-1:0] prev_key_q, prev_key_d;

    logic               enter;
    logic               final_next;
    logic [OP_W-1:0]    ent_op;

    always_comb begin
        state_d       = state_q;
        op_sel_d      = op_sel_q;
        stage_d       = stage_q;
        restart_d     = restart_q;
        busy_d        = busy_q;
        pending_d     = pending_q;
        key_snap_d    = key_snap_q;
        prev_key_d    = prev_key_q;
        sample_done_d = 1'b0;
        overrun_d     = 1'b0;
        enter         = 1'b0;
        ent_op        = '0;
        final_next    = next_q && (op_sel_q == LastOp);

        unique case (state_q)
            StIdle: begin
                op_sel_d  = '0;
                stage_d   = '0;
                restart_d = 1'b0;
                busy_d    = 1'b0;
                if (bus.sample_tick || pending_q) begin
                    state_d   = StRun;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                    enter     = 1'b1;
                end
            end
            StRun: begin
                if (bus.sample_tick && !final_next) begin
                    if (pending_q) overrun_d = 1'b1;
                    else           pending_d = 1'b1;
                end
                if (next_q) begin
                    // Commit the level that produced this slot's restart decision.
                    prev_key_d[op_sel_q] = key_snap_q;
                    stage_d              = '0;
                    if (final_next) begin
                        sample_done_d = 1'b1;
                        op_sel_d      = '0;
                        if (pending_q || bus.sample_tick) begin
                            // A tick landing alongside a pending one stays queued.
                            pending_d = pending_q && bus.sample_tick;
                            enter     = 1'b1;
                        end else begin
                            state_d   = StIdle;
                            busy_d    = 1'b0;
                            restart_d = 1'b0;
                        end
                    end else begin
                        op_sel_d = op_sel_q + 1'b1;
                        ent_op   = op_sel_q + 1'b1;
                        enter    = 1'b1;
                    end
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter) begin
            restart_d  = bus.key_on[ent_op] & ~prev_key_q[ent_op];
            key_snap_d = bus.key_on[ent_op];
        end

        next_d = (state_d == StRun) && (stage_d == LastStage);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            op_sel_q      <= '0;
            stage_q       <= '0;
            next_q        <= 1'b0;
            restart_q     <= 1'b0;
            busy_q        <= 1'b0;
            sample_done_q <= 1'b0;
            overrun_q     <= 1'b0;
            pending_q     <= 1'b0;
            key_snap_q    <= 1'b0;
            prev_key_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_sel_q      <= op_sel_d;
            stage_q       <= stage_d;
            next_q        <= next_d;
            restart_q     <= restart_d;
            busy_q        <= busy_d;
            sample_done_q <= sample_done_d;
            overrun_q     <= overrun_d;
            pending_q     <= pending_d;
            key_snap_q    <= key_snap_d;
            prev_key_q    <= prev_key_d;
        end
    end

    assign bus.op_sel      = op_sel_q;
    assign bus.stage       = stage_q;
    assign bus.next        = next_q;
    assign bus.restart     = restart_q;
    assign bus.busy        = busy_q;
    assign bus.sample_done = sample_done_q;
    assign bus.overrun     = overrun_q;
endmodule
